// File: rtl/counter_channel_controller.sv
// ============================================================================
// Module   : counter_channel_controller
// Brief    : Control logic for one 8254-style timer channel. Decodes control
//            words, sequences count writes, issues start/reload pulses, drives
//            OUT and serves count reads. Optional macro: COUNTER_LATCH_CMD_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module counter_channel_controller #(
    parameter logic [1:0] DEFAULT_RW   = 2'b11,
    parameter logic [2:0] DEFAULT_MODE = 3'd0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       wr_ctrl,
    input  logic       wr_data,
    input  logic       rd_data,
    input  logic [7:0] din,
    output logic [7:0] dout,
    input  logic       gate,
    output logic       out,
    output logic       ce_start_count,
    output logic [7:0] ce_initial_count_high,
    output logic [7:0] ce_initial_count_low,
    input  logic [7:0] ce_output_count_high,
    input  logic [7:0] ce_output_count_low,
    input  logic       ce_count_end
);

    localparam logic [2:0] c_IDLE      = 3'd0;
    localparam logic [2:0] c_WAIT_GATE = 3'd1;
    localparam logic [2:0] c_START     = 3'd2;
    localparam logic [2:0] c_COUNTING  = 3'd3;
    localparam logic [2:0] c_RELOAD    = 3'd4;

    localparam logic [1:0] c_RW_LATCH = 2'b00;
    localparam logic [1:0] c_RW_LSB   = 2'b01;
    localparam logic [1:0] c_RW_MSB   = 2'b10;
    localparam logic [1:0] c_RW_BOTH  = 2'b11;

    logic [2:0] r_state;
    logic [2:0] w_state_nxt;
    logic       r_out;
    logic       w_out_nxt;
    logic [1:0] r_rw;
    logic [2:0] r_mode;
    logic       r_wr_msb;
    logic       r_rd_msb;
    logic [7:0] r_init_hi;
    logic [7:0] r_init_lo;
    logic [7:0] r_dout;
    logic       r_end_d;

    logic       w_ctrl_load;
    logic       w_ctrl_latch;
    logic       w_data_wr;
    logic       w_rd;
    logic       w_end_rise;
    logic       w_is_mode2;
    logic       w_load_done;
    logic       w_first_byte;
    logic [2:0] w_ctrl_mode;
    logic       w_rd_sel_msb;
    logic       w_latch_full;
    logic [7:0] w_latch_hi;
    logic [7:0] w_latch_lo;
    logic [7:0] w_src_hi;
    logic [7:0] w_src_lo;
    logic       w_unused_din;

    assign w_unused_din = ^{din[7:6], din[0]};

    assign w_ctrl_load  = wr_ctrl && (din[5:4] != c_RW_LATCH);
    assign w_ctrl_latch = wr_ctrl && (din[5:4] == c_RW_LATCH);
    assign w_data_wr    = wr_data && !wr_ctrl;
    assign w_rd         = rd_data && !wr_ctrl && !wr_data;
    assign w_end_rise   = ce_count_end && !r_end_d;
    assign w_is_mode2   = (r_mode == 3'd2);
    assign w_ctrl_mode  = (din[3:1] == 3'd2) ? 3'd2 : 3'd0;
    assign w_load_done  = w_data_wr && ((r_rw != c_RW_BOTH) || r_wr_msb);
    assign w_first_byte = w_data_wr && ((r_rw != c_RW_BOTH) || !r_wr_msb);

    // Next state and OUT level; a loading control word overrides everything.
    always_comb begin
        w_state_nxt = r_state;
        w_out_nxt   = r_out;
        if (w_ctrl_load) begin
            w_state_nxt = c_IDLE;
            w_out_nxt   = (w_ctrl_mode == 3'd2);
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (w_load_done) w_state_nxt = c_WAIT_GATE;
                end
                c_WAIT_GATE: begin
                    if (gate) w_state_nxt = c_START;
                end
                c_START: begin
                    if (!w_is_mode2 && w_load_done) w_state_nxt = c_WAIT_GATE;
                    else                            w_state_nxt = c_COUNTING;
                end
                c_COUNTING: begin
                    if (w_is_mode2) begin
                        if (!gate) begin
                            w_state_nxt = c_WAIT_GATE;
                            w_out_nxt   = 1'b1;
                        end else if (w_end_rise) begin
                            w_state_nxt = c_RELOAD;
                            w_out_nxt   = 1'b0;
                        end
                    end else begin
                        if (w_load_done) begin
                            w_state_nxt = c_WAIT_GATE;
                        end else if (w_end_rise) begin
                            w_state_nxt = c_IDLE;
                            w_out_nxt   = 1'b1;
                        end
                    end
                end
                c_RELOAD: begin
                    w_out_nxt   = 1'b1;
                    w_state_nxt = gate ? c_START : c_WAIT_GATE;
                end
                default: w_state_nxt = c_IDLE;
            endcase
            if (!w_is_mode2 && w_first_byte) w_out_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_IDLE;
            r_out   <= 1'b0;
            r_end_d <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_out   <= w_out_nxt;
            r_end_d <= ce_count_end;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rw      <= DEFAULT_RW;
            r_mode    <= DEFAULT_MODE;
            r_wr_msb  <= 1'b0;
            r_init_hi <= 8'h00;
            r_init_lo <= 8'h00;
        end else if (w_ctrl_load) begin
            r_rw     <= din[5:4];
            r_mode   <= w_ctrl_mode;
            r_wr_msb <= 1'b0;
        end else if (w_data_wr) begin
            case (r_rw)
                c_RW_LSB: begin
                    r_init_lo <= din;
                    r_init_hi <= 8'h00;
                end
                c_RW_MSB: begin
                    r_init_hi <= din;
                    r_init_lo <= 8'h00;
                end
                default: begin
                    if (!r_wr_msb) r_init_lo <= din;
                    else           r_init_hi <= din;
                    r_wr_msb <= !r_wr_msb;
                end
            endcase
        end
    end

`ifdef COUNTER_LATCH_CMD_EN
    logic [1:0] r_latch_left;
    logic [7:0] r_latch_hi;
    logic [7:0] r_latch_lo;

    // Latch holds until every byte of the current RW format has been read.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_latch_left <= 2'd0;
            r_latch_hi   <= 8'h00;
            r_latch_lo   <= 8'h00;
        end else if (w_ctrl_latch && (r_latch_left == 2'd0)) begin
            r_latch_hi   <= ce_output_count_high;
            r_latch_lo   <= ce_output_count_low;
            r_latch_left <= (r_rw == c_RW_BOTH) ? 2'd2 : 2'd1;
        end else if (w_rd && (r_latch_left != 2'd0)) begin
            r_latch_left <= r_latch_left - 2'd1;
        end
    end

    assign w_latch_full = (r_latch_left != 2'd0);
    assign w_latch_hi   = r_latch_hi;
    assign w_latch_lo   = r_latch_lo;
`else
    logic w_unused_latch;

    assign w_unused_latch = w_ctrl_latch;
    assign w_latch_full   = 1'b0;
    assign w_latch_hi     = 8'h00;
    assign w_latch_lo     = 8'h00;
`endif

    assign w_src_hi     = w_latch_full ? w_latch_hi : ce_output_count_high;
    assign w_src_lo     = w_latch_full ? w_latch_lo : ce_output_count_low;
    assign w_rd_sel_msb = (r_rw == c_RW_MSB) || ((r_rw == c_RW_BOTH) && r_rd_msb);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_msb <= 1'b0;
            r_dout   <= 8'h00;
        end else if (w_ctrl_load) begin
            r_rd_msb <= 1'b0;
        end else if (w_rd) begin
            r_dout <= w_rd_sel_msb ? w_src_hi : w_src_lo;
            if (r_rw == c_RW_BOTH) r_rd_msb <= !r_rd_msb;
        end
    end

    assign dout                  = r_dout;
    assign out                   = r_out;
    assign ce_start_count        = (r_state == c_START);
    assign ce_initial_count_high = r_init_hi;
    assign ce_initial_count_low  = r_init_lo;

endmodule

`default_nettype wire

// File: tb/tb_counter_channel_controller.sv
// ============================================================================
// Module   : tb_counter_channel_controller
// Brief    : Directed plus randomized bench for counter_channel_controller.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_counter_channel_controller;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       wr_ctrl = 1'b0;
    logic       wr_data = 1'b0;
    logic       rd_data = 1'b0;
    logic       gate = 1'b0;
    logic       ce_count_end = 1'b0;
    logic [7:0] din = 8'h00;
    logic [7:0] ce_output_count_high = 8'h00;
    logic [7:0] ce_output_count_low = 8'h00;
    logic [7:0] dout;
    logic       out;
    logic       ce_start_count;
    logic [7:0] ce_initial_count_high;
    logic [7:0] ce_initial_count_low;

    int checks = 0;
    int errors = 0;
    int n_starts = 0;

    counter_channel_controller dut (
        .clk                   (clk),
        .rst                   (rst),
        .wr_ctrl               (wr_ctrl),
        .wr_data               (wr_data),
        .rd_data               (rd_data),
        .din                   (din),
        .dout                  (dout),
        .gate                  (gate),
        .out                   (out),
        .ce_start_count        (ce_start_count),
        .ce_initial_count_high (ce_initial_count_high),
        .ce_initial_count_low  (ce_initial_count_low),
        .ce_output_count_high  (ce_output_count_high),
        .ce_output_count_low   (ce_output_count_low),
        .ce_count_end          (ce_count_end)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (ce_start_count === 1'b1) n_starts++;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic ctrl_wr(input logic [7:0] b);
        wr_ctrl = 1'b1; din = b;
        tick();
        wr_ctrl = 1'b0;
    endtask

    task automatic data_wr(input logic [7:0] b);
        wr_data = 1'b1; din = b;
        tick();
        wr_data = 1'b0;
    endtask

    task automatic rd_chk(input string tag, input logic [7:0] exp);
        rd_data = 1'b1;
        tick();
        rd_data = 1'b0;
        check(tag, {8'h00, dout}, {8'h00, exp});
    endtask

    function automatic logic [15:0] init_count();
        return {ce_initial_count_high, ce_initial_count_low};
    endfunction

    // One mode-2 period: terminal count, one-cycle OUT low, then reload pulse.
    task automatic mode2_period(input int len);
        repeat (len) tick();
        ce_count_end = 1'b1;
        tick();
        check("m2_out_low", {15'd0, out}, 16'd0);
        check("m2_no_start_yet", {15'd0, ce_start_count}, 16'd0);
        ce_count_end = 1'b0;
        tick();
        check("m2_out_high", {15'd0, out}, 16'd1);
        check("m2_reload", {15'd0, ce_start_count}, 16'd1);
        tick();
        check("m2_reload_end", {15'd0, ce_start_count}, 16'd0);
    endtask

    initial begin
        int s0;
        logic [1:0]  rw;
        logic [2:0]  m;
        logic [7:0]  b0, b1, cw;
        logic [15:0] v, w, src, exp_init;
        logic        latched, out_before, feature;

`ifdef COUNTER_LATCH_CMD_EN
        feature = 1'b1;
`else
        feature = 1'b0;
`endif

        // Reset state
        repeat (3) tick();
        rst = 1'b0;
        tick();
        check("rst_out", {15'd0, out}, 16'd0);
        check("rst_start", {15'd0, ce_start_count}, 16'd0);
        check("rst_dout", {8'h00, dout}, 16'h0000);
        check("rst_init", init_count(), 16'h0000);

        // Default RW is LSB-then-MSB
        data_wr(8'hAA);
        data_wr(8'hBB);
        check("default_rw", init_count(), 16'hBBAA);

        // Mode 0, two-byte load
        gate = 1'b1;
        ctrl_wr(8'h30);
        check("m0_out_after_ctrl", {15'd0, out}, 16'd0);
        s0 = n_starts;
        data_wr(8'h0A);
        check("m0_no_start_mid_load", {15'd0, ce_start_count}, 16'd0);
        data_wr(8'h01);
        check("m0_init", init_count(), 16'h010A);
        check("m0_start_not_early", {15'd0, ce_start_count}, 16'd0);
        tick();
        check("m0_start_pulse", {15'd0, ce_start_count}, 16'd1);
        tick();
        check("m0_start_one_cycle", {15'd0, ce_start_count}, 16'd0);
        repeat (3) tick();
        ce_count_end = 1'b1;
        tick();
        check("m0_out_terminal", {15'd0, out}, 16'd1);
        repeat (4) tick();
        check("m0_out_stays", {15'd0, out}, 16'd1);
        check("m0_single_start", n_starts - s0, 16'd1);
        ce_count_end = 1'b0;

        // Mode 2, LSB only, two periods
        ctrl_wr(8'h14);
        check("m2_out_after_ctrl", {15'd0, out}, 16'd1);
        data_wr(8'h05);
        check("m2_init", init_count(), 16'h0005);
        tick();
        check("m2_first_start", {15'd0, ce_start_count}, 16'd1);
        tick();
        mode2_period(int'($urandom_range(2, 8)));
        mode2_period(int'($urandom_range(2, 8)));

        // Mode 2, gate dropped for four cycles
        s0 = n_starts;
        gate = 1'b0;
        tick();
        check("gate_low_out", {15'd0, out}, 16'd1);
        repeat (3) tick();
        check("gate_low_no_start", n_starts - s0, 16'd0);
        gate = 1'b1;
        tick();
        check("gate_return_start", {15'd0, ce_start_count}, 16'd1);
        tick();
        check("gate_return_single", n_starts - s0, 16'd1);

        // MSB-only load while gate is low
        gate = 1'b0;
        ctrl_wr(8'h20);
        check("msb_out_after_ctrl", {15'd0, out}, 16'd0);
        s0 = n_starts;
        data_wr(8'h20);
        check("msb_init", init_count(), 16'h2000);
        repeat (3) tick();
        check("msb_wait_gate", n_starts - s0, 16'd0);
        gate = 1'b1;
        tick();
        check("msb_start_on_gate", {15'd0, ce_start_count}, 16'd1);

        // Latch command and byte-ordered reads
        ctrl_wr(8'h30);
        ce_output_count_high = 8'h12; ce_output_count_low = 8'h34;
        out_before = out;
        ctrl_wr(8'h00);
        check("latch_cmd_out", {15'd0, out}, {15'd0, out_before});
        ce_output_count_high = 8'h56; ce_output_count_low = 8'h78;
        if (feature) begin
            rd_chk("latch_rd_lsb", 8'h34);
            rd_chk("latch_rd_msb", 8'h12);
            rd_chk("latch_rd_live", 8'h78);
            ctrl_wr(8'h00);
            ce_output_count_high = 8'h9A; ce_output_count_low = 8'hBC;
            ctrl_wr(8'h00);
            rd_chk("relatch_ignored_msb", 8'h56);
            rd_chk("relatch_ignored_lsb", 8'h78);
            rd_chk("relatch_released", 8'h9A);
        end else begin
            rd_chk("live_rd_lsb", 8'h78);
            rd_chk("live_rd_msb", 8'h56);
            rd_chk("live_rd_lsb2", 8'h78);
        end

        // Randomized loads and reads against an arithmetic model
        for (int i = 0; i < 24; i++) begin
            rw = 2'($urandom_range(1, 3));
            m  = 3'($urandom);
            b0 = 8'($urandom);
            b1 = 8'($urandom);
            gate = 1'($urandom);
            cw = {2'($urandom), rw, m, 1'($urandom)};
            ctrl_wr(cw);
            check("rnd_ctrl_out", {15'd0, out}, {15'd0, (m == 3'd2)});
            case (rw)
                2'b01: begin data_wr(b0); exp_init = 16'(b0); end
                2'b10: begin data_wr(b1); exp_init = 16'(b1) * 16'd256; end
                default: begin data_wr(b0); data_wr(b1); exp_init = 16'(b1) * 16'd256 + 16'(b0); end
            endcase
            check("rnd_init", init_count(), exp_init);
            v = 16'($urandom);
            w = 16'($urandom);
            {ce_output_count_high, ce_output_count_low} = v;
            latched = 1'b0;
            if ($urandom_range(0, 1) == 1) begin
                out_before = out;
                ctrl_wr({2'($urandom), 2'b00, 4'($urandom)});
                check("rnd_latch_out", {15'd0, out}, {15'd0, out_before});
                latched = feature;
            end
            {ce_output_count_high, ce_output_count_low} = w;
            src = latched ? v : w;
            if (rw == 2'b01) rd_chk("rnd_rd", 8'(src % 16'd256));
            else if (rw == 2'b10) rd_chk("rnd_rd", 8'(src / 16'd256));
            else begin
                rd_chk("rnd_rd_lo", 8'(src % 16'd256));
                rd_chk("rnd_rd_hi", 8'(src / 16'd256));
            end
        end

        // Simultaneous strobes
        gate = 1'b0;
        ctrl_wr(8'h10);
        ce_output_count_low = 8'hE1;
        rd_chk("pre_collide_rd", 8'hE1);
        ce_output_count_low = 8'h3C;
        wr_data = 1'b1; rd_data = 1'b1; din = 8'h77;
        tick();
        wr_data = 1'b0; rd_data = 1'b0;
        check("wr_rd_dout_holds", {8'h00, dout}, 16'h00E1);
        check("wr_rd_data_taken", init_count(), 16'h0077);
        wr_ctrl = 1'b1; wr_data = 1'b1; din = 8'h10;
        tick();
        wr_ctrl = 1'b0; wr_data = 1'b0;
        check("ctrl_data_ignored", init_count(), 16'h0077);

        // Reset during counting, coincident with terminal count
        gate = 1'b1;
        ctrl_wr(8'h30);
        data_wr(8'h11);
        data_wr(8'h22);
        tick();
        tick();
        ce_output_count_low = 8'hCD;
        rd_chk("pre_rst_rd", 8'hCD);
        rst = 1'b1; ce_count_end = 1'b1;
        #1;
        check("mid_rst_out", {15'd0, out}, 16'd0);
        check("mid_rst_start", {15'd0, ce_start_count}, 16'd0);
        check("mid_rst_dout", {8'h00, dout}, 16'h0000);
        tick();
        rst = 1'b0;
        s0 = n_starts;
        repeat (3) tick();
        ce_count_end = 1'b0;
        repeat (3) tick();
        check("post_rst_no_start", n_starts - s0, 16'd0);
        check("post_rst_out", {15'd0, out}, 16'd0);
        ctrl_wr(8'h30);
        data_wr(8'h02);
        data_wr(8'h00);
        tick();
        check("post_rst_restart", {15'd0, ce_start_count}, 16'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
